// File: rtl/pmc_sampler_pkg.sv
// Shared constants and types for the PMC snapshot sampler.
package pmc_sampler_pkg;

  // Frame geometry: one header word (sequence number) plus one word per counter.
  localparam int NUM_CNT    = 7;
  localparam int FRAME_LEN  = 8;
  localparam int CNT_STRIDE = 4;

  // Data-bus operation codes; this block only ever reads.
  localparam logic [1:0] DRW_IDLE = 2'b00;
  localparam logic [1:0] DRW_READ = 2'b10;

  // Snapshot sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ADDR = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/pmc_sampler_fifo.sv
// Synchronous show-ahead FIFO holding stream words (data + last flag).
// Reports the number of free slots so a whole frame can be admitted atomically.
module pmc_sampler_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [AW:0]   free
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Guard both ends so a misuse can never corrupt the pointers.
  always_comb begin
    do_push = push && (count != DEPTH_W);
    do_pop  = pop && (count != '0);
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign free     = DEPTH_W - count;

endmodule

// File: rtl/pmc_sampler.sv
// PMC snapshot sampler: reads the seven performance counters over the data
// bus on a timer tick or trigger and streams 8-word timestamped frames.
// Optional build macro PMC_SAMPLER_DELTA_EN: counter words carry the
// difference from the previously pushed frame instead of absolute values.
//
// Stream handshake: a word moves when s_valid && s_ready on a rising edge;
// while s_valid is high and s_ready is low, s_data and s_last hold steady.
module pmc_sampler
  import pmc_sampler_pkg::*;
#(
  parameter int unsigned PERIOD = 100000,
  parameter int          DEPTH  = 32,      // power of 2, at least FRAME_LEN
  parameter logic [31:0] BASE   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        trig,
  output logic        de,
  output logic [31:0] daddr,
  output logic [1:0]  drw,
  input  logic [31:0] din,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_data,
  output logic        s_last,
  output logic        busy,
  output logic [15:0] ovf_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] PERIOD_M1 = (PERIOD == 0) ? 32'd0 : 32'(PERIOD - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_CNT - 1);
  localparam logic [AW:0] FRAME_W   = (AW+1)'(FRAME_LEN);

  state_t      state;
  state_t      state_next;
  logic [2:0]  idx;
  logic [2:0]  idx_next;
  logic [31:0] timer;
  logic        tick;
  logic        req;
  logic        pending;
  logic        drop;
  logic [31:0] seq;
  logic [31:0] cap_q;
  logic [31:0] cnt_word;
  logic [15:0] ovf_q;
  logic        de_q;
  logic [31:0] daddr_q;
  logic [1:0]  drw_q;

  logic        fifo_push;
  logic [32:0] fifo_push_data;
  logic        fifo_pop;
  logic [32:0] fifo_pop_data;
  logic        fifo_empty;
  logic [AW:0] fifo_free;

  // Interval tick fires in the cycle the timer sits at PERIOD-1.
  always_comb begin
    tick = en && (PERIOD != 0) && (timer == PERIOD_M1);
    req  = tick || trig;
  end

  // Free-running interval timer, frozen while disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer <= '0;
    end else if (en && (PERIOD != 0)) begin
      timer <= (timer == PERIOD_M1) ? 32'd0 : timer + 32'd1;
    end
  end

  // Next-state logic: admit a frame only when all 8 words are guaranteed room.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (req || pending) begin
          if (fifo_free >= FRAME_W) begin
            state_next = HDR;
          end else begin
            drop = 1'b1;
          end
        end
      end
      HDR: begin
        idx_next   = 3'd0;
        state_next = ADDR;
      end
      ADDR: begin
        state_next = CAP;
      end
      CAP: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx + 3'd1;
          state_next = ADDR;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter index, sequence number, pending flag and drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      seq     <= '0;
      pending <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (state == DONE) begin
        seq <= seq + 32'd1;
      end
      // Requests while busy merge into one; IDLE always consumes the flag.
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (req) begin
        pending <= 1'b1;
      end
      if (drop && (ovf_q != 16'hFFFF)) begin
        ovf_q <= ovf_q + 16'd1;
      end
    end
  end

  // Bus outputs are registered from the next state so they are clean in ADDR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      de_q    <= 1'b0;
      drw_q   <= DRW_IDLE;
      daddr_q <= '0;
    end else begin
      de_q  <= (state_next == ADDR);
      drw_q <= (state_next == ADDR) ? DRW_READ : DRW_IDLE;
      if (state_next == ADDR) begin
        daddr_q <= BASE + 32'(idx_next) * 32'(CNT_STRIDE);
      end
    end
  end

  // Capture the slave's read data at the end of the address cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_q <= '0;
    end else if (state == ADDR) begin
      cap_q <= din;
    end
  end

`ifdef PMC_SAMPLER_DELTA_EN
  logic [31:0] prev_q [NUM_CNT];

  // Previous values advance only as counter words are pushed, so a dropped
  // snapshot leaves them alone and the next delta covers the gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        prev_q[k] <= '0;
      end
    end else if (state == CAP) begin
      prev_q[idx] <= cap_q;
    end
  end

  assign cnt_word = cap_q - prev_q[idx];
`else
  assign cnt_word = cap_q;
`endif

  // Push the header in HDR and one counter word per CAP; never stalls.
  always_comb begin
    fifo_push      = 1'b0;
    fifo_push_data = '0;
    if (state == HDR) begin
      fifo_push      = 1'b1;
      fifo_push_data = {1'b0, seq};
    end else if (state == CAP) begin
      fifo_push      = 1'b1;
      fifo_push_data = {(idx == LAST_IDX), cnt_word};
    end
  end

  assign fifo_pop = s_valid && s_ready;

  pmc_sampler_fifo #(
    .DEPTH (DEPTH),
    .W     (33)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  // Stream outputs read zero whenever no word is presented.
  always_comb begin
    s_valid = !fifo_empty;
    s_data  = fifo_empty ? 32'd0 : fifo_pop_data[31:0];
    s_last  = !fifo_empty && fifo_pop_data[32];
  end

  assign de        = de_q;
  assign daddr     = daddr_q;
  assign drw       = drw_q;
  assign busy      = (state != IDLE);
  assign ovf_count = ovf_q;

endmodule

// File: tb/tb_pmc_sampler.sv
// Directed bench for pmc_sampler (PERIOD=20, DEPTH=8, BASE=0).
// Honours PMC_SAMPLER_DELTA_EN when computing expected counter words.
module tb_pmc_sampler;

  localparam int PERIOD = 20;
  localparam int DEPTH  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        trig = 1'b0;
  logic        s_ready = 1'b0;
  logic        de;
  logic [31:0] daddr;
  logic [1:0]  drw;
  logic [31:0] din;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        busy;
  logic [15:0] ovf_count;

  always #5 clk = ~clk;

  pmc_sampler #(
    .PERIOD (PERIOD),
    .DEPTH  (DEPTH),
    .BASE   (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .trig      (trig),
    .de        (de),
    .daddr     (daddr),
    .drw       (drw),
    .din       (din),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .busy      (busy),
    .ovf_count (ovf_count)
  );

  // Slave model: counter k at address 4k, combinational on daddr.
  logic [31:0] cnt_val [7];
  always_comb begin
    din = 32'hDEAD_BEEF;
    if (daddr < 32'd28 && daddr[1:0] == 2'b00) din = cnt_val[daddr[4:2]];
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  logic [31:0] m_seq = 32'd0;
  logic [31:0] m_prev [7];

  // Monitor records transfers and bus activity; tasks check the records.
  logic [32:0] got_arr [0:1023];
  logic [31:0] addr_arr [0:1023];
  int          got_n = 0;
  int          addr_n = 0;
  int          de_cnt = 0;
  int          busy_cnt = 0;
  int          drw_err = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (s_valid && s_ready) begin
        got_arr[got_n & 1023] = {s_last, s_data};
        got_n++;
      end
      if (de) begin
        addr_arr[addr_n & 1023] = daddr;
        addr_n++;
        de_cnt++;
      end
      if (busy) busy_cnt++;
      if (drw !== (de ? 2'b10 : 2'b00)) drw_err++;
      if (prev_stall && (!s_valid || s_data !== prev_data || s_last !== prev_last)) stab_err++;
      prev_stall = s_valid && !s_ready;
      prev_data  = s_data;
      prev_last  = s_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    cyc(1);
    trig = 1'b0;
  endtask

  // Queue the frame the DUT should emit for the current counter values.
  task automatic make_frame();
    logic [31:0] v;
    exp_q.push_back({1'b0, m_seq});
    for (int k = 0; k < 7; k++) begin
      v = cnt_val[k];
`ifdef PMC_SAMPLER_DELTA_EN
      v = cnt_val[k] - m_prev[k];
      m_prev[k] = cnt_val[k];
`endif
      exp_q.push_back({(k == 6), v});
    end
    m_seq++;
  endtask

  // Wait until the DUT has been idle with an empty stream for 3 cycles.
  task automatic wait_quiet(input int budget, output bit timed_out);
    int quiet;
    quiet = 0;
    timed_out = 1'b1;
    cyc(2);
    for (int i = 0; i < budget; i++) begin
      quiet = (!busy && !s_valid) ? quiet + 1 : 0;
      if (quiet >= 3) begin
        timed_out = 1'b0;
        break;
      end
      cyc(1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    cyc(3);
    n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b exp 0", de); end
    n_checks++; if (daddr !== 32'd0) begin n_fail++; $display("FAIL reset_daddr: got %h exp 0", daddr); end
    n_checks++; if (drw !== 2'b00) begin n_fail++; $display("FAIL reset_drw: got %b exp 00", drw); end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b exp 0", s_valid); end
    n_checks++; if (s_last !== 1'b0) begin n_fail++; $display("FAIL reset_s_last: got %b exp 0", s_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d exp 0", ovf_count); end
    rst = 1'b1;
    cyc(2);
  endtask

  task automatic test_single_frame();
    int g0, a0, d0, b0, r0;
    bit to;
    logic [32:0] e;
    for (int k = 0; k < 7; k++) cnt_val[k] = 32'h100 + k;
    s_ready = 1'b1;
    g0 = got_n; a0 = addr_n; d0 = de_cnt; b0 = busy_cnt; r0 = drw_err;
    make_frame();
    pulse_trig();
    wait_quiet(80, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: got timeout exp idle"); end
    n_checks++; if (busy_cnt - b0 != 16) begin n_fail++; $display("FAIL single_busy_cycles: got %0d exp 16", busy_cnt - b0); end
    n_checks++; if (de_cnt - d0 != 7) begin n_fail++; $display("FAIL single_de_pulses: got %0d exp 7", de_cnt - d0); end
    n_checks++; if (drw_err != r0) begin n_fail++; $display("FAIL single_drw: got %0d bad cycles exp 0", drw_err - r0); end
    for (int i = 0; i < 7 && a0 + i < addr_n; i++) begin
      n_checks++;
      if (addr_arr[a0 + i] !== 32'(4 * i)) begin n_fail++; $display("FAIL single_daddr[%0d]: got %h exp %h", i, addr_arr[a0 + i], 4 * i); end
    end
    n_checks++; if (got_n - g0 != exp_q.size()) begin n_fail++; $display("FAIL single_word_count: got %0d exp %0d", got_n - g0, exp_q.size()); end
    for (int i = g0; i < got_n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (got_arr[i] !== e) begin n_fail++; $display("FAIL single_word[%0d]: got %h exp %h", i - g0, got_arr[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_timer();
    int g0, a0, d0;
    bit to;
    logic [32:0] e;
    s_ready = 1'b1;
    g0 = got_n; a0 = addr_n; d0 = de_cnt;
    for (int f = 0; f < 5; f++) make_frame();
    en = 1'b1;
    cyc(110);
    en = 1'b0;
    wait_quiet(100, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL timer_timeout: got timeout exp idle"); end
    n_checks++; if (de_cnt - d0 != 35) begin n_fail++; $display("FAIL timer_de_pulses: got %0d exp 35", de_cnt - d0); end
    for (int i = 0; i < 35 && a0 + i < addr_n; i++) begin
      n_checks++;
      if (addr_arr[a0 + i] !== 32'(4 * (i % 7))) begin n_fail++; $display("FAIL timer_daddr[%0d]: got %h exp %h", i, addr_arr[a0 + i], 4 * (i % 7)); end
    end
    n_checks++; if (got_n - g0 != exp_q.size()) begin n_fail++; $display("FAIL timer_word_count: got %0d exp %0d", got_n - g0, exp_q.size()); end
    for (int i = g0; i < got_n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (got_arr[i] !== e) begin n_fail++; $display("FAIL timer_word[%0d]: got %h exp %h", i - g0, got_arr[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    int g0;
    logic [32:0] e;
    for (int k = 0; k < 7; k++) cnt_val[k] = 32'h200 + 3 * k;
    s_ready = 1'b0;
    g0 = got_n;
    make_frame();
    pulse_trig();
    cyc(29);
    pulse_trig();
    cyc(29);
    pulse_trig();
    cyc(20);
    n_checks++; if (ovf_count !== 16'd2) begin n_fail++; $display("FAIL ovf_count: got %0d exp 2", ovf_count); end
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid_held: got %b exp 1", s_valid); end
    n_checks++; if (got_n != g0) begin n_fail++; $display("FAIL ovf_no_transfer: got %0d words exp 0", got_n - g0); end
    s_ready = 1'b1;
    cyc(20);
    n_checks++; if (got_n - g0 != 8) begin n_fail++; $display("FAIL ovf_word_count: got %0d exp 8", got_n - g0); end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b exp 0", s_valid); end
    for (int i = g0; i < got_n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (got_arr[i] !== e) begin n_fail++; $display("FAIL ovf_word[%0d]: got %h exp %h", i - g0, got_arr[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_pending();
    int g0, d0;
    bit to;
    logic [32:0] e;
    for (int k = 0; k < 7; k++) cnt_val[k] = 32'h300 + k;
    s_ready = 1'b1;
    g0 = got_n; d0 = de_cnt;
    make_frame();
    make_frame();
    trig = 1'b1;
    cyc(5);
    trig = 1'b0;
    wait_quiet(120, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL pending_timeout: got timeout exp idle"); end
    n_checks++; if (de_cnt - d0 != 14) begin n_fail++; $display("FAIL pending_de_pulses: got %0d exp 14", de_cnt - d0); end
    n_checks++; if (ovf_count !== 16'd2) begin n_fail++; $display("FAIL pending_ovf: got %0d exp 2", ovf_count); end
    n_checks++; if (got_n - g0 != exp_q.size()) begin n_fail++; $display("FAIL pending_word_count: got %0d exp %0d", got_n - g0, exp_q.size()); end
    for (int i = g0; i < got_n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (got_arr[i] !== e) begin n_fail++; $display("FAIL pending_word[%0d]: got %h exp %h", i - g0, got_arr[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_stall();
    int g0, s0, quiet;
    bit to;
    logic [3:0] pat;
    logic [32:0] e;
    pat = 4'b1001;  // s_ready sequence 1,0,0,1 (bit 0 first)
    for (int k = 0; k < 7; k++) cnt_val[k] = 32'h4000 + 16 * k;
    s_ready = 1'b1;
    g0 = got_n; s0 = stab_err;
    make_frame();
    pulse_trig();
    to = 1'b1;
    quiet = 0;
    for (int i = 0; i < 200; i++) begin
      s_ready = pat[i % 4];
      cyc(1);
      quiet = (i > 4 && !busy && !s_valid) ? quiet + 1 : 0;
      if (quiet >= 3) begin
        to = 1'b0;
        break;
      end
    end
    s_ready = 1'b1;
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: got timeout exp idle"); end
    n_checks++; if (stab_err != s0) begin n_fail++; $display("FAIL stall_stability: got %0d changes exp 0", stab_err - s0); end
    n_checks++; if (got_n - g0 != exp_q.size()) begin n_fail++; $display("FAIL stall_word_count: got %0d exp %0d", got_n - g0, exp_q.size()); end
    for (int i = g0; i < got_n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (got_arr[i] !== e) begin n_fail++; $display("FAIL stall_word[%0d]: got %h exp %h", i - g0, got_arr[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_values();
    int g0;
    bit to;
    logic [32:0] e;
    logic [31:0] exp_w3, exp_w4;
`ifdef PMC_SAMPLER_DELTA_EN
    exp_w3 = 32'd30;
    exp_w4 = 32'hFFFF_FFFE;
`else
    exp_w3 = 32'd80;
    exp_w4 = 32'd3;
`endif
    s_ready = 1'b1;
    g0 = got_n;
    cnt_val[2] = 32'd50;
    cnt_val[3] = 32'd5;
    make_frame();
    pulse_trig();
    wait_quiet(80, to);
    cnt_val[2] = 32'd80;
    cnt_val[3] = 32'd3;
    make_frame();
    pulse_trig();
    wait_quiet(80, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL values_timeout: got timeout exp idle"); end
    n_checks++; if (got_n - g0 != 16) begin n_fail++; $display("FAIL values_word_count: got %0d exp 16", got_n - g0); end
    n_checks++; if (got_arr[g0 + 11][31:0] !== exp_w3) begin n_fail++; $display("FAIL values_cnt2: got %h exp %h", got_arr[g0 + 11][31:0], exp_w3); end
    n_checks++; if (got_arr[g0 + 12][31:0] !== exp_w4) begin n_fail++; $display("FAIL values_cnt3: got %h exp %h", got_arr[g0 + 12][31:0], exp_w4); end
    for (int i = g0; i < got_n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (got_arr[i] !== e) begin n_fail++; $display("FAIL values_word[%0d]: got %h exp %h", i - g0, got_arr[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int g0;
    bit to;
    logic [32:0] e;
    s_ready = 1'b0;
    pulse_trig();
    cyc(5);
    rst = 1'b0;
    cyc(1);
    n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL midrst_de: got %b exp 0", de); end
    n_checks++; if (daddr !== 32'd0) begin n_fail++; $display("FAIL midrst_daddr: got %h exp 0", daddr); end
    n_checks++; if (drw !== 2'b00) begin n_fail++; $display("FAIL midrst_drw: got %b exp 00", drw); end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_s_valid: got %b exp 0", s_valid); end
    n_checks++; if (s_data !== 32'd0) begin n_fail++; $display("FAIL midrst_s_data: got %h exp 0", s_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL midrst_ovf: got %0d exp 0", ovf_count); end
    rst = 1'b1;
    m_seq = 32'd0;
    for (int k = 0; k < 7; k++) m_prev[k] = 32'd0;
    cyc(2);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo_empty: got %b exp 0", s_valid); end
    s_ready = 1'b1;
    g0 = got_n;
    make_frame();
    pulse_trig();
    wait_quiet(80, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL midrst_timeout: got timeout exp idle"); end
    n_checks++; if (got_n - g0 != exp_q.size()) begin n_fail++; $display("FAIL midrst_word_count: got %0d exp %0d", got_n - g0, exp_q.size()); end
    for (int i = g0; i < got_n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (got_arr[i] !== e) begin n_fail++; $display("FAIL midrst_word[%0d]: got %h exp %h", i - g0, got_arr[i], e); end
    end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 7; k++) begin
      cnt_val[k] = 32'd0;
      m_prev[k]  = 32'd0;
    end
    test_reset();
    test_single_frame();
    test_timer();
    test_overflow();
    test_pending();
    test_stall();
    test_values();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmc_sampler.md
Name: pmc_sampler

Overview:
- Bus initiator that reads the 7 performance-counter registers of the PMC slave over the data bus and streams timestamped snapshot frames out.
- The slave is the responder; this block drives `de`/`daddr`/`drw` and captures the returned read data.
- Snapshots start on a periodic interval timer or an explicit trigger pulse.
- Frames are buffered in an internal FIFO feeding a valid/ready stream, consumed by the UART/debug path.

Parameters:
- PERIOD, 100000, cycles between automatic snapshots; 0 disables the timer.
- DEPTH, 32, output FIFO depth in words; power of 2, must be ≥ 8.
- BASE, 32'h00000000, daddr of counter 0; counter k is read at BASE+4k.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- en  in  1  enables the interval timer; trig still works when low.
- trig  in  1  one-cycle snapshot request.
- de  out  1  data-bus enable, high during the read address phase.
- daddr  out  32  data-bus address.
- drw  out  2  bus op; 2'b10 = read, 2'b00 = idle. Never writes.
- din  in  32  read data returned by the slave (combinational on daddr).
- s_valid  out  1  stream word valid.
- s_ready  in  1  consumer ready.
- s_data  out  32  stream word.
- s_last  out  1  marks word 7 (last) of a frame.
- busy  out  1  FSM not in IDLE.
- ovf_count  out  16  snapshots dropped because the FIFO lacked room; saturates at 16'hFFFF.

Behaviour:
- Reset (rst==0 at posedge), all cleared:
  - de=0, daddr=0, drw=0, s_valid=0, s_last=0, busy=0, ovf_count=0.
  - FIFO emptied, timer=0, seq=0, pending=0, FSM→IDLE.
  - Reset mid-frame aborts the frame and discards FIFO contents.
- Timer: when en && PERIOD!=0, increments each cycle; at PERIOD-1 it wraps to 0 and raises an internal tick.
- Request = tick | trig.
  - A request in a non-IDLE state sets pending (1-deep; extra requests are merged and not counted).
  - pending is consumed on return to IDLE.
- Frame: 8 words: seq (32-bit, increments per accepted frame, wraps), then counters 0..6. s_last=1 on counter 6.
- FSM:
  - IDLE: on request (or pending), check FIFO free slots.
    - free ≥ 8: go to HDR.
    - Otherwise ovf_count++ (saturating); stay IDLE; seq unchanged.
  - HDR: push seq; idx=0; → ADDR.
  - ADDR: de=1, drw=2'b10, daddr=BASE+4*idx (all registered outputs, valid this cycle); → CAP.
  - CAP: de=0, drw=0; latch din (captured at the end of the ADDR cycle) and push it; if idx==6 → DONE, else idx++ and → ADDR.
  - DONE: seq++; → IDLE.
- Frame latency: 16 cycles from request to DONE. Counter k is sampled in cycle 2+2k after HDR.
  - Skew between counters is inherent and documented; counters are not frozen.
- Atomicity: the free≥8 check at frame start guarantees no push hits a full FIFO. Pushes never stall.
- Stream:
  - A word transfers when s_valid && s_ready.
  - s_data/s_last hold stable while s_valid && !s_ready.
  - A push and a pop in the same cycle are legal; count is unchanged.
- Simultaneous trig and tick count as one request.

Optional Feature:
- Macro: PMC_SAMPLER_DELTA_EN.
- Defined:
  - Words 1..7 carry the current value minus the previous frame's value for that counter (32-bit modular).
  - Seven previous-value registers reset to 0 and update only on pushed frames.
  - A dropped frame does not update them, so the next delta spans the gap.
- Undefined: absolute counter values; no previous-value registers.

Decomposition:
- Package pmc_sampler_pkg holds:
  - NUM_CNT=7, FRAME_LEN=8, CNT_STRIDE=4.
  - DRW_IDLE=2'b00, DRW_READ=2'b10.
  - FSM state enum {IDLE, HDR, ADDR, CAP, DONE}.
- Sub-module pmc_sampler_fifo: synchronous DEPTH×33 FIFO (data + last).
  - Provides push, pop, and a free-count output; active-low sync reset.

Test Plan:
- Reset then trig with the slave model returning 32'h100+k at address 4k → stream: 0, 0x100, 0x101, …, 0x106; s_last only on 0x106; busy high 16 cycles.
- PERIOD=20, en=1, s_ready=1, 100 cycles → 5 frames with seq 0..4; de pulses exactly 7 per frame; daddr sequence 0x00..0x18.
- DEPTH=8, s_ready=0, three trigs spaced 30 cycles → one frame buffered, ovf_count=2; then raise s_ready → exactly 8 words out.
- trig held 5 cycles during a frame → exactly one extra frame follows (pending), seq advances by 2 total.
- s_ready toggling 1,0,0,1 during output → s_data stable across stalls; no loss or duplication.
- With PMC_SAMPLER_DELTA_EN: counter 2 reads 50, then 80 → second frame word 3 = 30; counter 3 reads 5, then 3 → 32'hFFFFFFFE. rst low at cycle 6 of a frame → all outputs 0 next cycle, FIFO empty.
